// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
//
// Receives 11-bit PS/2 device-to-host frames (start, 8 data bits LSB first,
// odd parity, stop) and presents each accepted frame as a 10-bit word.
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   ps2_clk    in   PS/2 device clock (asynchronous, idle high)
//   ps2_data   in   PS/2 device data  (asynchronous, idle high)
//   buffer     out  last accepted frame: [0]=start, [8:1]=data, [9]=parity
//   flag       out  one-cycle pulse when buffer takes a new frame
//   frame_err  out  one-cycle pulse when a complete frame is rejected
//
// Parameter
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk falling edge after which a
//                   partially received frame is discarded
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, frames with even parity over the data
//                        and parity bits are rejected; otherwise parity is
//                        only stored in buffer[9].
//
// Timing: the frame result moves through three registered stages after the
// eleventh falling edge (end-of-frame capture, verdict, output), so flag
// rises on the fourth clk edge after the first synchronizer flop sees the
// eleventh ps2_clk low.
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] buffer,
  output logic       flag,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'd10;

  // Synchronizers; the third clock flop only serves edge detection.
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_s3_q, clk_s3_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s2_q, dat_s2_d;

  // Frame assembly
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [WD_W-1:0] wd_q, wd_d;

  // Stage 1: end-of-frame capture
  logic       eof_q, eof_d;
  logic       stop_q, stop_d;
  logic [9:0] frame_q, frame_d;

  // Stage 2: verdict
  logic ok_q, ok_d;
  logic bad_q, bad_d;

  // Stage 3: outputs
  logic [9:0] buffer_q, buffer_d;
  logic       flag_q, flag_d;
  logic       frame_err_q, frame_err_d;

  logic fall;
  logic parity_ok;

  // -------------------------------------------------------------------------
  // Synchronizers and edge detect
  // -------------------------------------------------------------------------
  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    clk_s3_d = clk_s2_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
  end

  assign fall = ~clk_s2_q & clk_s3_q;

  // -------------------------------------------------------------------------
  // Bit counter, shift register and watchdog
  // -------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wd_d      = wd_q;
    eof_d     = 1'b0;
    stop_d    = stop_q;
    frame_d   = frame_q;

    if (fall) begin
      wd_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is line noise or a lost frame tail: stay idle.
        if (!dat_s2_q) begin
          shift_d   = {dat_s2_q, shift_q[9:1]};
          bit_cnt_d = 4'd1;
        end
      end else if (bit_cnt_q == LAST_BIT) begin
        // Stop bit: the shift register already holds bits 0..9.
        eof_d     = 1'b1;
        stop_d    = dat_s2_q;
        frame_d   = shift_q;
        bit_cnt_d = 4'd0;
      end else begin
        // Shifting in from the top lands bit k at position k after ten bits.
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wd_q == WD_LAST) begin
        bit_cnt_d = 4'd0;
        shift_d   = '0;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Verdict and outputs
  // -------------------------------------------------------------------------
`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data plus parity bit must contain an odd number of ones.
  assign parity_ok = ^frame_q[9:1];
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    ok_d  = eof_q & stop_q & parity_ok;
    bad_d = eof_q & ~(stop_q & parity_ok);

    flag_d      = ok_q;
    frame_err_d = bad_q;
    buffer_d    = buffer_q;
    // frame_q only changes on end-of-frame, so it is still valid here.
    if (ok_q) begin
      buffer_d = frame_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_s3_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      wd_q        <= '0;
      eof_q       <= 1'b0;
      stop_q      <= 1'b0;
      frame_q     <= '0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      buffer_q    <= 10'h000;
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_s3_q    <= clk_s3_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wd_q        <= wd_d;
      eof_q       <= eof_d;
      stop_q      <= stop_d;
      frame_q     <= frame_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
      buffer_q    <= buffer_d;
      flag_q      <= flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign buffer    = buffer_q;
  assign flag      = flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
//
// Drives PS/2 frames into ps2_keyboard_rx and checks flag / frame_err pulse
// counts and the buffer contents. Directed frames come from a vector table;
// randomized frames are predicted from the frame rules (start 0, LSB-first
// data, odd parity, stop 1). Hand-written sequences cover output latency,
// a bad start bit, the watchdog and a reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 15;   // clk cycles per ps2_clk half period
  localparam int IDLE    = 30;   // clk cycles after each frame

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] buffer;
  logic       flag;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int err_cnt = 0;
  logic prev_flag = 1'b0;
  logic prev_err = 1'b0;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .buffer   (buffer),
    .flag     (flag),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts pulses and checks width / exclusivity.
  always @(negedge clk) begin
    if (flag || frame_err) begin
      checks = checks + 1;
      if (flag && frame_err) begin
        errors = errors + 1;
        $display("FAIL pulse_exclusive: flag=%0b frame_err=%0b required not both high", flag, frame_err);
      end else if ((flag && prev_flag) || (frame_err && prev_err)) begin
        errors = errors + 1;
        $display("FAIL pulse_width: flag=%0b/%0b err=%0b/%0b required one-cycle pulses",
                 prev_flag, flag, prev_err, frame_err);
      end
    end
    if (flag && !prev_flag) flag_cnt = flag_cnt + 1;
    if (frame_err && !prev_err) err_cnt = err_cnt + 1;
    prev_flag = flag;
    prev_err  = frame_err;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         exp_flag;
    int         exp_err;
    logic [9:0] exp_buf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2_edge(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_edge(1'b0);
    for (int i = 0; i < 8; i++) ps2_edge(d[i]);
    ps2_edge(p);
    ps2_edge(s);
    ps2_data = 1'b1;
    repeat (IDLE) @(negedge clk);
  endtask

  // Reference: a frame is accepted when its stop bit is 1 and, with parity
  // checking built in, data plus parity hold an odd number of ones.
  function automatic logic model_accept(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = p ? 1 : 0;
    for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
`ifdef PS2_PARITY_CHECK_EN
    return s && (ones % 2 == 1);
`else
    return s;
`endif
  endfunction

  task automatic frame_check(input string name, input logic [7:0] d, input logic p,
                             input logic s, input int ef, input int ee, input logic [9:0] eb);
    int f0, e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame(d, p, s);
    $display("frame %s data=0x%02h par=%0b stop=%0b -> flags=%0d errs=%0d buffer=0x%03h",
             name, d, p, s, flag_cnt - f0, err_cnt - e0, buffer);
    check({name, "_flag"}, 32'(flag_cnt - f0), 32'(ef));
    check({name, "_err"}, 32'(err_cnt - e0), 32'(ee));
    check({name, "_buf"}, 32'(buffer), 32'(eb));
  endtask

  initial begin
    logic [9:0] exp_buf;
    logic [7:0] rd;
    logic       rp, rs, acc;
    int         f0, e0;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 10'h038};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 10'h3E0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 10'h038};
    vecs[3] = '{8'h1C, 1'b0, 1'b0, 0, 1, 10'h038};
`ifdef PS2_PARITY_CHECK_EN
    vecs[4] = '{8'h1C, 1'b1, 1'b1, 0, 1, 10'h038};
`else
    vecs[4] = '{8'h1C, 1'b1, 1'b1, 1, 0, 10'h238};
`endif
    vecs[5] = '{8'hE0, 1'b0, 1'b1, 1, 0, 10'h1C0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1, 0, 10'h200};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_buffer", 32'(buffer), 32'h000);
    check("reset_flag", 32'(flag), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      frame_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop,
                  vecs[i].exp_flag, vecs[i].exp_err, vecs[i].exp_buf);
    end

    // Latency: flag high after the 4th clk edge following capture of the
    // 11th ps2_clk low, and low on the edges either side.
    ps2_edge(1'b0);
    for (int i = 0; i < 8; i++) ps2_edge(rd_const(i));
    ps2_edge(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) check("latency_e3", 32'(flag), 32'h0);
      if (k == 4) check("latency_e4", 32'(flag), 32'h1);
      if (k == 5) check("latency_e5", 32'(flag), 32'h0);
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (IDLE) @(negedge clk);
    $display("latency frame 0x1C -> buffer=0x%03h", buffer);
    check("latency_buf", 32'(buffer), 32'h038);

    // Bad start bit is ignored, following frame is received intact
    f0 = flag_cnt;
    e0 = err_cnt;
    ps2_edge(1'b1);
    repeat (IDLE) @(negedge clk);
    $display("bad start -> flags=%0d errs=%0d", flag_cnt - f0, err_cnt - e0);
    check("badstart_flag", 32'(flag_cnt - f0), 32'h0);
    check("badstart_err", 32'(err_cnt - e0), 32'h0);
    frame_check("after_badstart", 8'h5A, 1'b1, 1'b1, 1, 0, 10'h2B4);

    // Watchdog: 5 bits then silence longer than the timeout
    f0 = flag_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) ps2_edge(1'b0);
    repeat (TIMEOUT + 60) @(negedge clk);
    $display("partial frame + idle -> flags=%0d errs=%0d", flag_cnt - f0, err_cnt - e0);
    check("timeout_flag", 32'(flag_cnt - f0), 32'h0);
    check("timeout_err", 32'(err_cnt - e0), 32'h0);
    frame_check("after_timeout", 8'h1C, 1'b0, 1'b1, 1, 0, 10'h038);

    // Reset in mid-frame (after 6 bits); reset acts without a clk edge
    for (int i = 0; i < 6; i++) ps2_edge(1'b1 ^ (i == 0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset mid-frame -> buffer=0x%03h", buffer);
    check("midreset_buffer", 32'(buffer), 32'h000);
    repeat (3) @(negedge clk);
    check("midreset_flag", 32'(flag), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame_check("after_reset", 8'h1C, 1'b0, 1'b1, 1, 0, 10'h038);

    // Randomized frames against the reference rules
    exp_buf = 10'h038;
    for (int n = 0; n < 30; n++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 7) != 0);
      acc = model_accept(rd, rp, rs);
      if (acc) exp_buf = {rp, rd, 1'b0};
      frame_check($sformatf("rand%0d", n), rd, rp, rs, acc ? 1 : 0, acc ? 0 : 1, exp_buf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bits of 0x1C, LSB first, for the latency sequence
  function automatic logic rd_const(input int i);
    logic [7:0] v;
    v = 8'h1C;
    return v[i];
  endfunction

  // Overall time bound
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time bound");
  end

endmodule
